// File: rtl/ifu.sv
// ifu: PC owner; fetches one instruction at a time over imem req/ack and hands it downstream over valid/ready; optional perf counters under IFU_PERF_CNT_EN
module ifu #(
  parameter logic [31:0] RESET_PC = 32'h80000000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] pc,
  input  logic        commit_taken,
  input  logic [31:0] commit_target,
  output logic        fetch_err,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt
);
  typedef enum logic [1:0] {IDLE, FETCH, VALID, ERR} state_t;
  state_t state, state_n;
  logic [31:0] pc_n, inst_n, nxt;
  logic req_n, val_n, err_n, mis;
  assign imem_addr = pc;
  assign nxt = commit_taken ? commit_target : pc + 32'd4;
  assign mis = |nxt[1:0];
  always_comb begin
    state_n = state;
    pc_n = pc;
    inst_n = inst;
    req_n = imem_req;
    val_n = inst_valid;
    err_n = fetch_err;
    case (state)
      IDLE: begin
        state_n = FETCH;
        req_n = 1'b1;
      end
      FETCH: if (imem_ack) begin
        inst_n = imem_rdata;
        req_n = 1'b0;
        val_n = 1'b1;
        state_n = VALID;
      end
      VALID: if (inst_ready) begin
        pc_n = nxt;
        val_n = 1'b0;
        state_n = mis ? ERR : FETCH;
        req_n = !mis;
        err_n = mis;
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pc <= RESET_PC;
      inst <= '0;
      imem_req <= 1'b0;
      inst_valid <= 1'b0;
      fetch_err <= 1'b0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      inst <= inst_n;
      imem_req <= req_n;
      inst_valid <= val_n;
      fetch_err <= err_n;
    end
  end
`ifdef IFU_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      perf_fetch_cnt <= perf_fetch_cnt + {31'd0, state == VALID && inst_ready};
      perf_stall_cnt <= perf_stall_cnt + {31'd0, state == FETCH && !imem_ack};
    end
  end
`else
  assign perf_fetch_cnt = '0;
  assign perf_stall_cnt = '0;
`endif
endmodule
